stopwatch_lap: RTL and testbench
================================

# stopwatch_lap

Parametrised successor to the four-digit stopwatch controller. It is an N-digit BCD up/down timer with a clock-derived tick prescaler, start/stop toggle, lap freeze and countdown with an expiry flag. It sits between the button/switch conditioning logic and SevenSegmentControl. Its packed `digits` bus and `digit_point` mask feed the display controller's `dataIn` and `digitPoint` directly.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 100: count rate. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `NUM_DIGITS`, default 4: number of BCD digits, 1–8.
- `DP_POS`, default 2: index of the digit whose decimal point is lit.
- `clk` input, 1: system clock, rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `start_stop` input, 1: level from debounced/synchronised button. Acts on the rising edge.
- `clear` input, 1: level. Acts on the rising edge. Zeroes the count and returns to IDLE.
- `lap` input, 1: level. Acts on the rising edge. Toggles the display freeze.
- `count_down` input, 1: 0 = count up, 1 = count down. Sampled on each tick.
- `load` input, 1: single-cycle strobe. Loads `load_value`. Honoured only in IDLE or PAUSE.
- `load_value` input, 4*NUM_DIGITS: BCD preset. Digit i is at `[4i+3:4i]`. Nibbles above 9 are saturated to 9.
- `digits` output, 4*NUM_DIGITS: displayed BCD value, registered.
- `digit_point` output, NUM_DIGITS: one-hot at `DP_POS`, constant.
- `running` output, 1: high in RUN.
- `lap_active` output, 1: high while the display is frozen.
- `expired` output, 1: high in EXPIRED.

## Operation
- Edge detect: each of `start_stop`, `clear` and `lap` is registered once. An event is `x & ~x_q`.
- States (shared enum):
  - IDLE. Count = 0, except after a load.
  - RUN
  - PAUSE
  - EXPIRED
- Transitions:
  - IDLE → RUN on start.
  - RUN → PAUSE on start.
  - PAUSE → RUN on start.
  - RUN → EXPIRED when counting down and a tick would take the count below 0 (count is already 0 at the tick).
  - EXPIRED → IDLE on clear.
  - EXPIRED: start is ignored.
  - Any state → IDLE on clear.
- Priority within one cycle: clear > load > start. Lap is independent of these, except that clear also forces `lap_active` = 0.
- Prescaler:
  - Counts 0..DIV-1 only in RUN. It is held at 0 in every other state.
  - Tick = prescaler at DIV-1.
- Counter: a chain of NUM_DIGITS BCD digits.
  - Up: increment with carry. All-9s wraps to all-0s and keeps running.
  - Down: decrement with borrow. From 0 it does not wrap; it moves to EXPIRED and the count stays 0.
  - A `count_down` change mid-run takes effect at the next tick.
- Lap:
  - Lap event while `lap_active` = 0: capture the live count into the display register and set `lap_active`. The internal count keeps advancing.
  - Second lap event: clear `lap_active`. The display follows the live count again.
  - Lap is accepted in every state except IDLE.
- `digits` = `lap_active` ? lap register : live count.

## Timing
- Reset values: all digits 0, lap register 0, state IDLE, prescaler 0, edge registers 0, `running`, `lap_active` and `expired` all 0.
- Event latency: input rises at cycle n → edge register at n+1 → state and flags update at n+2.
- First tick after entering RUN comes DIV cycles later. `digits` changes one cycle after the tick.
- Pause preserves the count. The prescaler restarts from 0 on resume, so the partial interval is discarded (accepted error < 1 tick).
- A clear coinciding with a tick leaves count = 0 with no increment.
- A load coinciding with start: load applies, the start is dropped.
- `reset_n` asserted mid-run forces all reset values immediately and asynchronously. Deassertion is synchronised upstream.

## Structure
- Package `stopwatch_pkg` holds:
  - `sw_state_t` (IDLE, RUN, PAUSE, EXPIRED)
  - `BCD_MAX` = 4'd9
  - function `bcd_sat(nibble)`
- Sub-module `bcd_digit`: one digit with `inc`/`dec` enables, `carry_out`/`borrow_out`, `load` and `is_zero`. NUM_DIGITS copies are chained in a generate loop.
- Top FSM, prescaler, edge detectors and lap register stay in `stopwatch_lap`.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), NUM_DIGITS=4, DP_POS=2.
- Reset:
  - Stimulus: `reset_n` low mid-count at 0x0123.
  - Response: `digits`=0x0000, `running`=0 in the same cycle. `digit_point`=4'b0100 throughout.
- Count up:
  - Stimulus: start pulse, run 125 ticks.
  - Response: `digits`=0x0125. First change to 0x0001 occurs 12 cycles after the start rise.
- Wrap:
  - Stimulus: load 0x9998, start, 2 ticks.
  - Response: `digits`=0x0000, still `running`=1.
- Countdown expiry:
  - Stimulus: `count_down`=1, load 0x0003, start.
  - Response: 0x0002, 0x0001, 0x0000 on successive ticks. Next tick → `expired`=1, `running`=0, `digits`=0x0000. A start pulse is ignored; clear → IDLE, `expired`=0.
- Lap:
  - Stimulus: lap at count 0x0040, run 20 more ticks.
  - Response: `digits` holds 0x0040. Second lap → `digits`=0x0060.
- Pause and collisions:
  - Pause at 0x0050 for 100 cycles → `digits` stays 0x0050.
  - Clear and start in the same cycle → IDLE, 0x0000.
  - Clear while `lap_active` → `lap_active`=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and helpers for the stopwatch_lap slice.
//   sw_state_t : controller state (IDLE, RUN, PAUSE, EXPIRED)
//   BCD_MAX    : largest legal BCD nibble
//   bcd_sat()  : clamps a nibble into the BCD range 0..9
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit of the stopwatch counter chain.
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous zero (highest priority)
//   load         : load saturated load_val
//   inc / dec    : count enables (carry / borrow in)
//   q            : digit value
//   carry_out    : inc while at 9 (rolls over)
//   borrow_out   : dec while at 0 (rolls under)
//   is_zero      : q == 0
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       is_zero
);

  assign is_zero    = (q == 4'd0);
  assign carry_out  = inc & (q == BCD_MAX);
  assign borrow_out = dec & is_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= 4'd0;
    else if (clr)  q <= 4'd0;
    else if (load) q <= bcd_sat(load_val);
    else if (inc)  q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    else if (dec)  q <= is_zero ? BCD_MAX : q - 4'd1;
  end

endmodule

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: N-digit BCD up/down stopwatch with tick prescaler,
// start/stop toggle, lap freeze and countdown expiry.
//   clk, reset_n  : clock, async active-low reset
//   start_stop    : level, rising edge toggles run/pause
//   clear         : level, rising edge zeroes count and returns to IDLE
//   lap           : level, rising edge toggles display freeze
//   count_down    : 1 = count down, sampled on each tick
//   load          : strobe, loads load_value in IDLE/PAUSE
//   load_value    : BCD preset, digit i at [4i+3:4i]
//   digits        : displayed BCD value
//   digit_point   : one-hot decimal point mask at DP_POS
//   running       : high in RUN
//   lap_active    : high while display is frozen
//   expired       : high in EXPIRED
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int NUM_DIGITS = 4,
  parameter int DP_POS     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  input  logic                    count_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_point,
  output logic                    running,
  output logic                    lap_active,
  output logic                    expired
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [NUM_DIGITS-1:0] DP_MASK = NUM_DIGITS'(1) << DP_POS;

  sw_state_t state;

  // Button levels are registered once (in_q), then edge-detected against a
  // second stage so the event is itself a clean registered pulse. Actions
  // therefore land two edges after the input rises.
  logic [2:0] in_q, in_qq, ev;
  logic       ss_ev, clr_ev, lap_ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q  <= '0;
      in_qq <= '0;
    end else begin
      in_q  <= {lap, clear, start_stop};
      in_qq <= in_q;
    end
  end

  assign ev     = in_q & ~in_qq;
  assign ss_ev  = ev[0];
  assign clr_ev = ev[1];
  assign lap_ev = ev[2];

  // Prescaler and tick
  logic [PW-1:0] pre;
  logic          tick, all_zero, expire, stay_run, load_en;

  assign tick     = (state == RUN) && (pre == PW'(DIV - 1));
  assign expire   = tick & count_down & all_zero;
  assign stay_run = (state == RUN) && !clr_ev && !ss_ev && !expire;
  assign load_en  = load && !clr_ev && (state == IDLE || state == PAUSE);

  // Anything leaving RUN resets the prescaler, so a resume discards the
  // partial interval and the first tick is always DIV cycles after entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pre <= '0;
    else if (stay_run) pre <= tick ? '0 : pre + 1'b1;
    else               pre <= '0;
  end

  // Digit chain
  logic [NUM_DIGITS-1:0][3:0] cnt;
  logic [NUM_DIGITS-1:0]      inc, dec, carry, borrow, zero;

  assign all_zero = &zero;
  // Down-count stops at zero: the tick becomes the expiry instead.
  assign inc[0]   = tick & ~count_down;
  assign dec[0]   = tick & count_down & ~all_zero;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    if (i > 0) begin : g_chain
      assign inc[i] = carry[i-1];
      assign dec[i] = borrow[i-1];
    end
    bcd_digit u_dig (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (clr_ev),
      .load       (load_en),
      .load_val   (load_value[4*i +: 4]),
      .inc        (inc[i]),
      .dec        (dec[i]),
      .q          (cnt[i]),
      .carry_out  (carry[i]),
      .borrow_out (borrow[i]),
      .is_zero    (zero[i])
    );
  end

  // Controller FSM; priority clear > load > start, expiry beats start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
    end else if (clr_ev) begin
      state   <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (!load && ss_ev) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (expire) begin
            state   <= EXPIRED;
            running <= 1'b0;
            expired <= 1'b1;
          end else if (ss_ev) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Lap freeze
  logic [NUM_DIGITS-1:0][3:0] lap_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_reg    <= '0;
      lap_active <= 1'b0;
    end else if (clr_ev) begin
      lap_active <= 1'b0;
    end else if (lap_ev && state != IDLE) begin
      if (lap_active) begin
        lap_active <= 1'b0;
      end else begin
        lap_reg    <= cnt;
        lap_active <= 1'b1;
      end
    end
  end

  assign digits      = lap_active ? lap_reg : cnt;
  assign digit_point = DP_MASK;

endmodule

// File: tb/tb_stopwatch_lap.sv
module tb_stopwatch_lap;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic        count_down = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] digits;
  logic [3:0]  digit_point;
  logic        running, lap_active, expired;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_lap #(
    .CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(4), .DP_POS(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .count_down (count_down),
    .load       (load),
    .load_value (load_value),
    .digits     (digits),
    .digit_point(digit_point),
    .running    (running),
    .lap_active (lap_active),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; cyc(1); lap = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value = v; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1);
    chk("rst_digits", digits, 32'h0000);
    chk("rst_running", running, 0);
    chk("rst_lap", lap_active, 0);
    chk("rst_expired", expired, 0);
    chk("dp", digit_point, 4'b0100);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    // first tick timing, then count to 0x0123 and reset mid-count
    pulse_start();
    cyc(10);
    chk("first_pre", digits, 32'h0000);
    cyc(1);
    chk("first_tick", digits, 32'h0001);
    cyc(1220);
    chk("cnt_123", digits, 32'h0123);
    chk("cnt_run", running, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_digits", digits, 32'h0000);
    chk("async_running", running, 0);
    chk("dp_rst", digit_point, 4'b0100);
    @(posedge clk); #1 reset_n = 1'b1;
    cyc(2);

    // count up 125 ticks, then clear
    pulse_start();
    cyc(1251);
    chk("cnt_125", digits, 32'h0125);
    chk("cnt_125_run", running, 1);
    pulse_clear();
    cyc(1);
    chk("clr_digits", digits, 32'h0000);
    chk("clr_running", running, 0);

    // wrap all-9s to all-0s
    do_load(16'h9998);
    chk("load_9998", digits, 32'h9998);
    pulse_start();
    cyc(11);
    chk("wrap_9999", digits, 32'h9999);
    cyc(10);
    chk("wrap_0000", digits, 32'h0000);
    chk("wrap_run", running, 1);
    pulse_clear();
    cyc(1);

    // load saturation
    do_load(16'hA3F1);
    chk("load_sat", digits, 32'h9391);

    // load coinciding with start event: load wins, start dropped
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    do_load(16'h0042);
    chk("ldst_digits", digits, 32'h0042);
    chk("ldst_run0", running, 0);
    cyc(15);
    chk("ldst_hold", digits, 32'h0042);
    chk("ldst_run1", running, 0);

    // countdown and expiry
    count_down = 1'b1;
    do_load(16'h0003);
    pulse_start();
    cyc(11);
    chk("dn_2", digits, 32'h0002);
    cyc(10);
    chk("dn_1", digits, 32'h0001);
    cyc(10);
    chk("dn_0", digits, 32'h0000);
    chk("dn_0_run", running, 1);
    cyc(9);
    chk("dn_pre_exp", expired, 0);
    cyc(1);
    chk("exp_flag", expired, 1);
    chk("exp_run", running, 0);
    chk("exp_digits", digits, 32'h0000);
    pulse_start();
    cyc(5);
    chk("exp_ign_start", expired, 1);
    chk("exp_ign_run", running, 0);
    pulse_clear();
    cyc(1);
    chk("exp_clr", expired, 0);
    chk("exp_clr_run", running, 0);
    count_down = 1'b0;

    // pause at 0x0050
    pulse_start();
    cyc(501);
    chk("pre_pause", digits, 32'h0050);
    pulse_start();
    cyc(1);
    chk("pause_run", running, 0);
    chk("pause_digits", digits, 32'h0050);
    cyc(100);
    chk("pause_hold", digits, 32'h0050);
    pulse_lap();
    cyc(1);
    chk("pause_lap", lap_active, 1);
    pulse_clear();
    cyc(1);
    chk("clr_lap", lap_active, 0);
    chk("clr_lap_digits", digits, 32'h0000);

    // lap freeze while running
    pulse_start();
    cyc(401);
    chk("lap_at_40", digits, 32'h0040);
    pulse_lap();
    cyc(1);
    chk("lap_on", lap_active, 1);
    chk("lap_frz", digits, 32'h0040);
    cyc(198);
    chk("lap_hold", digits, 32'h0040);
    pulse_lap();
    cyc(1);
    chk("lap_off", lap_active, 0);
    chk("lap_live", digits, 32'h0060);

    // clear and start in the same cycle
    clear = 1'b1; start_stop = 1'b1;
    cyc(1);
    clear = 1'b0; start_stop = 1'b0;
    cyc(1);
    chk("cs_run", running, 0);
    chk("cs_digits", digits, 32'h0000);
    cyc(20);
    chk("cs_run_hold", running, 0);
    chk("cs_dig_hold", digits, 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
